// File: rtl/xs3_pkg.sv
// Shared Excess-3 constants and the packer FSM state encoding.
package xs3_pkg;

    // Excess-3 code = BCD digit + 3; legal codes span 3..12.
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'b0011;
    localparam logic [3:0] XS3_MAX    = 4'b1100;

    // Packer FSM encoding. Kept as plain constants so older tools and
    // existing waveform decoders keep working.
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

endpackage

// File: rtl/xs3_digit_packer_if.sv
// Digit-in / word-out handshake bundle for the Excess-3 packer.
// master = upstream digit source plus downstream word sink (the environment),
// slave  = the packer itself.
interface xs3_digit_packer_if #(
    parameter int DIGITS = 4
) ();

    // frame control
    logic                  abort;

    // digit input channel
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_digit;

    // packed word output channel
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_err;

    modport master (
        output abort,
        output in_valid,
        output in_digit,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_err,
        output out_ready
    );

    modport slave (
        input  abort,
        input  in_valid,
        input  in_digit,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_err,
        input  out_ready
    );

endinterface

// File: rtl/xs3_digit_decode.sv
// Combinational Excess-3 to 8421 BCD digit decoder.
// Illegal codes decode to zero so that downstream packing never sees a
// value above 9; the illegal flag lets the consumer track the error.
import xs3_pkg::*;

module xs3_digit_decode (
    input  logic [3:0] xs3,
    output logic [3:0] bcd,
    output logic       illegal
);

    // Range check against the legal Excess-3 window, then remove the offset.
    always_comb begin
        illegal = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
        bcd     = illegal ? 4'd0 : (xs3 - XS3_OFFSET);
    end

endmodule

// File: rtl/xs3_digit_packer.sv
// Serial Excess-3 digit receiver: collects DIGITS digits (MSD first),
// converts each to BCD and presents the packed word with a sticky error flag.
// Two states: COLLECT accepts digits, HOLD presents the word until taken.
// There is no bypass from HOLD back to accepting in the same cycle, so the
// sustained rate is one word per DIGITS+1 cycles.
import xs3_pkg::*;

module xs3_digit_packer #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    xs3_digit_packer_if.slave  bus
);

    // count only ever holds 0..DIGITS-1; it wraps to 0 on the last digit.
    localparam int             CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

    logic [0:0]           state;
    logic [CW-1:0]        count;
    logic [4*DIGITS-1:0]  shreg;
    logic                 err_acc;

    logic [3:0]           dec_bcd;
    logic                 dec_ill;
    logic [4*DIGITS-1:0]  shreg_nxt;
    logic                 err_nxt;
    logic                 in_xfer;
    logic                 out_xfer;

    xs3_digit_decode u_dec (
        .xs3     (bus.in_digit),
        .bcd     (dec_bcd),
        .illegal (dec_ill)
    );

    // Handshake outputs are pure state decodes; the word is the shift register.
    assign bus.in_ready  = (state == ST_COLLECT);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_bcd   = shreg;
    assign bus.out_err   = err_acc;

    // An abort in COLLECT swallows any digit offered in the same cycle.
    assign in_xfer  = bus.in_valid && (state == ST_COLLECT) && !bus.abort;
    assign out_xfer = bus.out_ready && (state == ST_HOLD);

    // New digit enters the LSB nibble; older digits move toward the MSD.
    generate
        if (DIGITS == 1) begin : g_shift_one
            assign shreg_nxt = dec_bcd;
        end else begin : g_shift_many
            assign shreg_nxt = {shreg[4*DIGITS-5:0], dec_bcd};
        end
    endgenerate

    // The first digit of a word starts a fresh error accumulation.
    assign err_nxt = ((count == '0) ? 1'b0 : err_acc) | dec_ill;

    // FSM, digit counter, shift register and error accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_COLLECT;
            count   <= '0;
            shreg   <= '0;
            err_acc <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (bus.abort) begin
                        count   <= '0;
                        shreg   <= '0;
                        err_acc <= 1'b0;
                    end else if (in_xfer) begin
                        shreg   <= shreg_nxt;
                        err_acc <= err_nxt;
                        if (count == LAST) begin
                            count <= '0;
                            state <= ST_HOLD;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Abort is deliberately ignored here: a finished word
                    // is always delivered.
                    if (out_xfer) begin
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: doc/xs3_digit_packer.md
Name: xs3_digit_packer

Overview:
Serial Excess-3 digit receiver that sits directly upstream of the packed-BCD datapath. It accepts one Excess-3 digit per valid/ready handshake, most-significant digit first. Each digit is converted to 8421 BCD and checked for a legal code. DIGITS digits are packed into one BCD word, which is presented on an output valid/ready port with a per-word error flag.

Parameters:
DIGITS, 4, number of decimal digits per output word (legal range 1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
abort  input  1  synchronous frame abort; discards the partially collected word
in_valid  input  1  in_digit is valid this cycle
in_ready  output  1  block accepts in_digit this cycle
in_digit  input  4  Excess-3 coded digit
out_valid  output  1  out_bcd/out_err hold a complete word
out_ready  input  1  downstream accepts the word
out_bcd  output  4*DIGITS  packed BCD; MSD in the top nibble
out_err  output  1  at least one digit of this word was an illegal Excess-3 code

Behaviour:
- Reset and state:
  - Reset is synchronous and active-high on clk; it has priority over every other input.
  - Reset values: in_ready=1, out_valid=0, out_bcd=0, out_err=0, digit count=0, state=COLLECT.
- Handshakes:
  - Input transfer occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs on a rising edge with out_valid & out_ready.
- FSM has two states: COLLECT and HOLD.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - On each input transfer, the decoded nibble shifts into the LSB nibble of the shift register, existing nibbles move up one position, and count increments.
  - On the transfer that brings count to DIGITS: go to HOLD, reset count to 0, set out_valid=1 the next cycle.
  - Latency is 1 cycle from the last digit's transfer to out_valid.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_bcd and out_err stay stable until the output transfer.
  - On the output transfer, go to COLLECT. in_ready is 1 again the following cycle; there is no same-cycle bypass.
  - Sustained throughput is 1 word per DIGITS+1 cycles.
- Decode:
  - Legal Excess-3 codes are 4'b0011..4'b1100; bcd = in_digit - 3, computed in 4 bits.
  - Illegal codes are 0000, 0001, 0010, 1101, 1110, 1111. An illegal code stores nibble 4'b0000 and sets the error accumulator.
  - The error accumulator is sticky for the word and is cleared when a new word starts (first digit transfer with count=0) or on abort/reset.
  - out_err reflects the accumulator for the held word.
- Abort:
  - In COLLECT: clear count, the shift register and the error accumulator. A digit offered in the same cycle is dropped, even though in_ready=1 that cycle.
  - In HOLD: ignored. A complete word is never discarded.
- Boundaries:
  - in_valid while in HOLD is ignored, and the digit must be held by the sender.
  - If out_ready is high in the same cycle out_valid first rises, the transfer completes that edge.
  - DIGITS=1 gives one digit per word with a 2-cycle period.

Decomposition:
- Shared package xs3_pkg holds:
  - constants XS3_OFFSET=4'd3, XS3_MIN=4'b0011, XS3_MAX=4'b1100;
  - the state encoding (COLLECT=1'b0, HOLD=1'b1).
- One sub-module: xs3_digit_decode (combinational, in: 4-bit xs3; out: 4-bit bcd, 1-bit illegal). It is reused by other Excess-3 consumers.

Test Plan:
1. Nominal word, DIGITS=4: send 0111,1000,1001,1010 back-to-back with out_ready=1 -> out_bcd=16'h4567, out_err=0, out_valid high exactly 1 cycle, 1 cycle after the 4th transfer.
2. Code boundaries: send 0011,1100,0011,1100 -> out_bcd=16'h0909, out_err=0.
3. Illegal code: send 0111,0001,1001,1010 -> out_bcd=16'h4067, out_err=1. The next word 0100,0100,0100,0100 -> 16'h1111 with out_err=0, confirming the accumulator clears.
4. Backpressure: complete a word with out_ready=0 for 3 cycles -> out_valid and out_bcd stable, and in_ready=0 throughout. With in_valid=1 during HOLD, no digit is consumed. After out_ready=1, in_ready=1 on the next cycle.
5. Abort and reset: after 2 digits assert abort (with in_valid=1) -> the digit is dropped, then 4 fresh digits 1000 x4 -> 16'h5555. Repeat with rst instead of abort mid-frame -> all outputs return to their reset values the next cycle. Assert abort in HOLD -> the word is still delivered.
6. Interleaved stalls: in_valid toggled 1,0,1,0,... with digits 0100,0101,0110,0111 -> 16'h1234; count does not advance on idle cycles.
